// File: rtl/controller_8085_gen_if.sv
// rtl/controller_8085_gen_if.sv - instruction, flag, handshake and strobe bundle for controller_8085_gen
//
// Purpose: groups every signal between the 8085-style controller and its
// datapath/memory so the controller takes a single bus port.
//   master modport (controller): consumes opcode/funct/z/cy/mem_ready/intr,
//                                drives strobes, selects, inta, bus_err, state_o.
//   slave modport (datapath/bench): the mirror image.
// Signals:
//   opcode, funct [OPW]   instruction fields from the instruction register
//   z, cy                 zero and carry flags
//   mem_ready             memory completion handshake
//   intr                  interrupt request
//   pcwrite .. regwrite   write and memory strobes
//   pcsrc [2]             00 ALU, 01 target, 10 interrupt vector
//   memsrcA [2]           00 PC, 11 direct address
//   inta, bus_err         interrupt acknowledge, sticky bus error
//   state_o [3]           current state code for debug
interface controller_8085_gen_if #(
  parameter int OPW = 5
);
  logic [OPW-1:0] opcode;
  logic [OPW-1:0] funct;
  logic           z;
  logic           cy;
  logic           mem_ready;
  logic           intr;
  logic           pcwrite;
  logic           irwrite;
  logic           read;
  logic           write;
  logic           Accwrite;
  logic           cywrite;
  logic           zwrite;
  logic           regwrite;
  logic [1:0]     pcsrc;
  logic [1:0]     memsrcA;
  logic           inta;
  logic           bus_err;
  logic [2:0]     state_o;

  modport master (
    input  opcode, funct, z, cy, mem_ready, intr,
    output pcwrite, irwrite, read, write, Accwrite, cywrite, zwrite, regwrite,
    output pcsrc, memsrcA, inta, bus_err, state_o
  );

  modport slave (
    output opcode, funct, z, cy, mem_ready, intr,
    input  pcwrite, irwrite, read, write, Accwrite, cywrite, zwrite, regwrite,
    input  pcsrc, memsrcA, inta, bus_err, state_o
  );
endinterface

// File: rtl/controller_8085_gen.sv
// rtl/controller_8085_gen.sv - multicycle 8085-style control FSM with memory wait timeout
//
// Purpose: sequences fetch/decode/execute for a small accumulator machine,
// times out stalled memory accesses into a sticky bus error and HALT.
// Optional feature: define CONTROLLER_8085_GEN_INTR_EN to add the interrupt
// enable bit (EI/DI) and the INTA acknowledge state; otherwise intr is ignored.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    controller_8085_gen_if.master (instruction fields, flags,
//          mem_ready, intr in; strobes, selects, inta, bus_err, state_o out)
// Parameters:
//   OPW       opcode/funct width
//   WAIT_MAX  memory wait cycles tolerated before a bus error
module controller_8085_gen #(
  parameter int OPW      = 5,
  parameter int WAIT_MAX = 7
) (
  input logic                   clk,
  input logic                   reset,
  controller_8085_gen_if.master bus
);

  localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  localparam logic [OPW-1:0] OP_ALU = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP_SYS = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_LDA = OPW'(5'b01101);
  localparam logic [OPW-1:0] OP_STA = OPW'(5'b01110);
  localparam logic [OPW-1:0] OP_JMP = OPW'(5'b01111);
  localparam logic [OPW-1:0] OP_JNZ = OPW'(5'b10000);
  localparam logic [OPW-1:0] OP_JNC = OPW'(5'b10001);

  localparam logic [OPW-1:0] F_EI   = OPW'(5'b01100);
  localparam logic [OPW-1:0] F_DI   = OPW'(5'b01101);
  localparam logic [OPW-1:0] F_HLT  = OPW'(5'b01110);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_ALU    = 3'd2,
    S_MRD    = 3'd3,
    S_MWR    = 3'd4,
    S_BRANCH = 3'd5,
    S_HALT   = 3'd6,
    S_INTA   = 3'd7
  } state_t;

  state_t         state;
  state_t         next_state;
  state_t         done_state;
  logic [CW-1:0]  wait_cnt;
  logic           waiting;
  logic           timeout;
  logic           take_branch;
  logic           irq_pending;
  logic           bus_err_q;

  // Output values before reset gating.
  logic           pcwrite_d;
  logic           irwrite_d;
  logic           read_d;
  logic           write_d;
  logic           acc_write_d;
  logic           cywrite_d;
  logic           zwrite_d;
  logic [1:0]     pcsrc_d;
  logic [1:0]     memsrc_d;
  logic           inta_d;

  // Only these states wait on mem_ready; elsewhere mem_ready is ignored.
  assign waiting = (state == S_FETCH) || (state == S_MRD) || (state == S_MWR);

  // mem_ready in the WAIT_MAX cycle still wins, so the error needs it low.
  assign timeout = waiting && !bus.mem_ready && (wait_cnt == CW'(WAIT_MAX));

  assign take_branch = (bus.opcode == OP_JMP)
                    || ((bus.opcode == OP_JNZ) && !bus.z)
                    || ((bus.opcode == OP_JNC) && !bus.cy);

`ifdef CONTROLLER_8085_GEN_INTR_EN
  logic ie;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ie <= 1'b0;
    end else if (state == S_DECODE && bus.opcode == OP_SYS && bus.funct == F_EI) begin
      ie <= 1'b1;
    end else if (state == S_DECODE && bus.opcode == OP_SYS && bus.funct == F_DI) begin
      ie <= 1'b0;
    end else if (state == S_INTA) begin
      ie <= 1'b0;
    end
  end

  // ie is sampled before an EI in DECODE takes effect, so EI itself
  // never diverts to INTA.
  assign irq_pending = ie && bus.intr;
`else
  logic unused_intr;
  assign unused_intr = bus.intr;
  assign irq_pending = 1'b0;
`endif

  // Where a completed instruction goes next.
  assign done_state = irq_pending ? S_INTA : S_FETCH;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Every entry into a waiting state is a state change, so clearing on any
  // change covers "clear on entry"; the counter saturates at WAIT_MAX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (next_state != state) begin
      wait_cnt <= '0;
    end else if (waiting && !bus.mem_ready && wait_cnt != CW'(WAIT_MAX)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_err_q <= 1'b0;
    end else if (timeout) begin
      bus_err_q <= 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      S_FETCH: begin
        if (bus.mem_ready)  next_state = S_DECODE;
        else if (timeout)   next_state = S_HALT;
        else                next_state = S_FETCH;
      end
      S_DECODE: begin
        if (bus.opcode == OP_ALU)                               next_state = S_ALU;
        else if (bus.opcode == OP_LDA)                          next_state = S_MRD;
        else if (bus.opcode == OP_STA)                          next_state = S_MWR;
        else if (bus.opcode == OP_JMP || bus.opcode == OP_JNZ
                 || bus.opcode == OP_JNC)                       next_state = S_BRANCH;
        else if (bus.opcode == OP_SYS && bus.funct == F_HLT)    next_state = S_HALT;
        else                                                    next_state = done_state;
      end
      S_ALU:    next_state = done_state;
      S_MRD, S_MWR: begin
        if (bus.mem_ready)  next_state = done_state;
        else if (timeout)   next_state = S_HALT;
        else                next_state = state;
      end
      S_BRANCH: next_state = done_state;
      S_HALT:   next_state = S_HALT;
      S_INTA:   next_state = S_FETCH;
      default:  next_state = S_FETCH;
    endcase
  end

  // Output decode.
  always_comb begin
    pcwrite_d   = 1'b0;
    irwrite_d   = 1'b0;
    read_d      = 1'b0;
    write_d     = 1'b0;
    acc_write_d = 1'b0;
    cywrite_d   = 1'b0;
    zwrite_d    = 1'b0;
    pcsrc_d     = 2'b00;
    memsrc_d    = 2'b00;
    inta_d      = 1'b0;
    unique case (state)
      S_FETCH: begin
        read_d = !timeout;
        if (bus.mem_ready) begin
          irwrite_d = 1'b1;
          pcwrite_d = 1'b1;
        end
      end
      S_ALU: begin
        acc_write_d = 1'b1;
        cywrite_d   = 1'b1;
        zwrite_d    = 1'b1;
      end
      S_MRD: begin
        read_d      = !timeout;
        memsrc_d    = 2'b11;
        acc_write_d = bus.mem_ready;
      end
      S_MWR: begin
        write_d  = !timeout;
        memsrc_d = 2'b11;
      end
      S_BRANCH: begin
        pcsrc_d   = 2'b01;
        pcwrite_d = take_branch;
      end
      S_INTA: begin
        inta_d    = 1'b1;
        pcwrite_d = 1'b1;
        pcsrc_d   = 2'b10;
      end
      default: ;
    endcase
  end

  // Reset gates the outputs combinationally: the state register already
  // reads FETCH during reset, which would otherwise drive read.
  assign bus.pcwrite  = pcwrite_d   && !reset;
  assign bus.irwrite  = irwrite_d   && !reset;
  assign bus.read     = read_d      && !reset;
  assign bus.write    = write_d     && !reset;
  assign bus.Accwrite = acc_write_d && !reset;
  assign bus.cywrite  = cywrite_d   && !reset;
  assign bus.zwrite   = zwrite_d    && !reset;
  assign bus.regwrite = 1'b0;
  assign bus.pcsrc    = reset ? 2'b00 : pcsrc_d;
  assign bus.memsrcA  = reset ? 2'b00 : memsrc_d;
  assign bus.inta     = inta_d      && !reset;
  assign bus.bus_err  = bus_err_q;
  assign bus.state_o  = state;

endmodule

// File: tb/tb_controller_8085_gen.sv
// tb/tb_controller_8085_gen.sv - directed self-checking bench for controller_8085_gen
module tb_controller_8085_gen;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  controller_8085_gen_if #(.OPW(5)) bus ();

  controller_8085_gen #(.OPW(5), .WAIT_MAX(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  function automatic logic [8:0] strobes;
    return {bus.pcwrite, bus.irwrite, bus.read, bus.write, bus.Accwrite,
            bus.cywrite, bus.zwrite, bus.regwrite, bus.inta};
  endfunction

  // From FETCH with mem_ready=1: decode a branch and check pcwrite in BRANCH.
  task automatic run_branch(input string tag, input logic [4:0] op, input logic zz,
                            input logic cc, input logic exp_pw);
    bus.opcode = op; bus.z = zz; bus.cy = cc; bus.mem_ready = 1'b1;
    tick;
    tick;
    settle;
    check({tag, "_state"}, bus.state_o, 5);
    check({tag, "_pcwrite"}, bus.pcwrite, exp_pw);
    check({tag, "_pcsrc"}, bus.pcsrc, 2'b01);
    tick;
    settle;
    check({tag, "_back"}, bus.state_o, 0);
  endtask

  // From FETCH with mem_ready=1: an instruction that decodes straight back to FETCH.
  task automatic run_nop(input string tag, input logic [4:0] op, input logic [4:0] f);
    bus.opcode = op; bus.funct = f; bus.mem_ready = 1'b1;
    tick;
    settle;
    check({tag, "_dec"}, bus.state_o, 1);
    tick;
    settle;
    check({tag, "_fetch"}, bus.state_o, 0);
  endtask

  // From FETCH: ALU op, returns the state observed right after the ALU cycle.
  task automatic run_alu(output logic [2:0] after_state);
    bus.opcode = 5'b00000; bus.mem_ready = 1'b1;
    tick;
    tick;
    settle;
    check("alu_acc", bus.Accwrite, 1);
    tick;
    settle;
    after_state = bus.state_o;
  endtask

  initial begin
    logic [2:0] st;
    reset = 1'b1;
    bus.opcode = 5'b0; bus.funct = 5'b0; bus.z = 1'b0; bus.cy = 1'b0;
    bus.mem_ready = 1'b1; bus.intr = 1'b0;
    #3;
    check("rst_state", bus.state_o, 0);
    check("rst_strobes", strobes(), 9'h0);
    check("rst_bus_err", bus.bus_err, 0);

    @(negedge clk);
    reset = 1'b0;
    settle;
    check("fetch_read", bus.read, 1);
    check("fetch_irwrite", bus.irwrite, 1);
    check("fetch_pcwrite", bus.pcwrite, 1);
    check("fetch_pcsrc", bus.pcsrc, 0);
    check("fetch_memsrc", bus.memsrcA, 0);

    // ALU: states 0,1,2,0 with Accwrite only in ALU
    tick; settle;
    check("alu_s1", bus.state_o, 1);
    check("alu_dec_acc", bus.Accwrite, 0);
    tick; settle;
    check("alu_s2", bus.state_o, 2);
    check("alu_flags", {bus.Accwrite, bus.cywrite, bus.zwrite, bus.read}, 4'b1110);
    tick; settle;
    check("alu_s0", bus.state_o, 0);
    check("alu_acc_off", bus.Accwrite, 0);

    // LDA with three wait cycles
    bus.opcode = 5'b01101;
    tick; settle;
    check("lda_dec", bus.state_o, 1);
    tick;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = (i == 3);
      settle;
      check("lda_state", bus.state_o, 3);
      check("lda_read", bus.read, 1);
      check("lda_memsrc", bus.memsrcA, 2'b11);
      check("lda_acc", bus.Accwrite, (i == 3));
      tick;
    end
    bus.mem_ready = 1'b1;
    settle;
    check("lda_done", bus.state_o, 0);
    check("lda_bus_err", bus.bus_err, 0);

    // Branches
    run_branch("jnz_z1", 5'b10000, 1'b1, 1'b0, 1'b0);
    run_branch("jnz_z0", 5'b10000, 1'b0, 1'b0, 1'b1);
    run_branch("jnc_c1", 5'b10001, 1'b0, 1'b1, 1'b0);
    run_branch("jnc_c0", 5'b10001, 1'b1, 1'b0, 1'b1);
    run_branch("jmp", 5'b01111, 1'b1, 1'b1, 1'b1);

    // Decode-to-fetch codes
    run_nop("nop", 5'b00100, 5'b01111);
    run_nop("unknown", 5'b00101, 5'b00000);
    run_nop("di", 5'b00100, 5'b01101);

    // Interrupts
    run_nop("ei", 5'b00100, 5'b01100);
    bus.intr = 1'b1;
    run_alu(st);
`ifdef CONTROLLER_8085_GEN_INTR_EN
    check("inta_state", st, 7);
    check("inta_strobe", bus.inta, 1);
    check("inta_pcsrc", bus.pcsrc, 2'b10);
    check("inta_pcwrite", bus.pcwrite, 1);
    tick; settle;
    check("inta_back", bus.state_o, 0);
    run_alu(st);
    check("ie_cleared", st, 0);
`else
    check("intr_ignored", st, 0);
    check("inta_zero", bus.inta, 0);
`endif
    bus.intr = 1'b0;

    // STA with mem_ready on exactly the WAIT_MAX cycle: success
    bus.opcode = 5'b01110; bus.mem_ready = 1'b1;
    tick; tick;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = (i == 7);
      settle;
      check("sta_edge_write", bus.write, 1);
      check("sta_edge_state", bus.state_o, 4);
      tick;
    end
    bus.mem_ready = 1'b1;
    settle;
    check("sta_edge_done", bus.state_o, 0);
    check("sta_edge_err", bus.bus_err, 0);

    // STA never ready: 7 write cycles, then write drops and HALT
    tick; tick;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      settle;
      check("sta_to_write", bus.write, 1);
      tick;
    end
    settle;
    check("sta_to_drop", bus.write, 0);
    check("sta_to_state", bus.state_o, 4);
    tick; settle;
    check("sta_to_halt", bus.state_o, 6);
    check("sta_to_err", bus.bus_err, 1);
    bus.mem_ready = 1'b1; bus.intr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick; settle;
      check("halt_hold", bus.state_o, 6);
      check("halt_strobes", strobes(), 9'h0);
      check("halt_err", bus.bus_err, 1);
    end
    bus.intr = 1'b0;

    // Reset recovers, HLT instruction halts without an error
    reset = 1'b1;
    settle;
    check("rec_state", bus.state_o, 0);
    check("rec_err", bus.bus_err, 0);
    reset = 1'b0;
    bus.opcode = 5'b00100; bus.funct = 5'b01110;
    tick; tick; settle;
    check("hlt_state", bus.state_o, 6);
    check("hlt_err", bus.bus_err, 0);
    check("hlt_strobes", strobes(), 9'h0);

    // Reset in the middle of MRD
    reset = 1'b1;
    settle;
    reset = 1'b0;
    bus.opcode = 5'b01101;
    tick; tick;
    bus.mem_ready = 1'b0;
    settle;
    check("mrd_pre", {bus.state_o, bus.read}, {3'd3, 1'b1});
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_strobes", strobes(), 9'h0);
    check("mid_rst_state", bus.state_o, 0);
    check("mid_rst_memsrc", bus.memsrcA, 0);
    reset = 1'b0;
    settle;
    check("post_rst_state", bus.state_o, 0);
    check("post_rst_read", bus.read, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/controller_8085_gen.md
CONTROLLER_8085_GEN -- requirements
Module: controller_8085_gen

Interface
REQ-001 SHALL have parameter OPW, default 5, meaning opcode and funct field width.
REQ-002 SHALL have parameter WAIT_MAX, default 7, meaning the maximum number of memory wait cycles before a bus error.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports opcode and funct, input, OPW each, instruction fields from the instruction register.
REQ-006 SHALL have ports z and cy, input, 1 each, the zero and carry flags.
REQ-007 SHALL have port mem_ready, input, 1, memory completion handshake.
REQ-008 SHALL have port intr, input, 1, interrupt request (used only with INTR_EN).
REQ-009 SHALL have ports pcwrite, irwrite, read, write, Accwrite, cywrite, zwrite and regwrite, output, 1 each, write and memory strobes.
REQ-010 SHALL have port pcsrc, output, 2, PC source select: 00 ALU, 01 target, 10 interrupt vector.
REQ-011 SHALL have port memsrcA, output, 2, memory address select: 00 PC, 11 direct address.
REQ-012 SHALL have ports inta and bus_err, output, 1 each, interrupt acknowledge and sticky bus error.
REQ-013 SHALL have port state_o, output, 3, current state code for debug.

Function
REQ-014 SHALL implement states FETCH=0, DECODE=1, ALU=2, MRD=3, MWR=4, BRANCH=5, HALT=6, INTA=7; outputs are decoded from state, with pcwrite in BRANCH conditional on the flags.
REQ-015 FETCH SHALL drive read=1 and memsrcA=00 while waiting for mem_ready.
- Cycle with mem_ready=1: irwrite=1, pcwrite=1, pcsrc=00, then go to DECODE.
- Strobes other than read SHALL stay 0 while waiting.
REQ-016 DECODE SHALL select the next state in one cycle:
- opcode 00000 -> ALU
- 01101 (LDA) -> MRD
- 01110 (STA) -> MWR
- 01111, 10000, 10001 -> BRANCH
- opcode 00100 with funct 01110 -> HALT
- opcode 00100 with funct 01111 (NOP) -> FETCH
- any other code -> FETCH, treated as NOP.
REQ-017 ALU SHALL assert Accwrite, cywrite and zwrite for one cycle, then go to FETCH.
REQ-018 MRD SHALL assert read with memsrcA=11; on mem_ready it asserts Accwrite for that cycle, then goes to FETCH.
REQ-019 MWR SHALL assert write with memsrcA=11 until mem_ready, then go to FETCH.
REQ-020 BRANCH SHALL assert pcwrite with pcsrc=01, then go to FETCH:
- JMP: unconditionally.
- JNZ: only when z=0.
- JNC: only when cy=0.
REQ-021 A wait counter, log2(WAIT_MAX+1) bits wide, SHALL:
- clear on entry to FETCH, MRD or MWR;
- increment each cycle mem_ready=0 in those states.
If it reaches WAIT_MAX with mem_ready still 0, the block sets bus_err=1, drops read/write that cycle and enters HALT.
REQ-022 mem_ready arriving on the same cycle the counter reaches WAIT_MAX SHALL count as success (no error).
REQ-023 HALT SHALL hold all strobes at 0 and remain there until reset; intr does not exit HALT.
REQ-024 bus_err SHALL remain 1 until reset.
REQ-025 mem_ready outside FETCH, MRD and MWR SHALL be ignored.

Reset
REQ-026 Asserting reset SHALL immediately force state=FETCH, wait counter=0, bus_err=0, ie=0, and drive every strobe and inta to 0, including mid-operation.
REQ-027 While reset is held, read and irwrite SHALL be 0.
REQ-028 The first fetch SHALL begin on the first clk edge after reset deasserts.

Configuration
REQ-029 With macro CONTROLLER_8085_GEN_INTR_EN defined:
- An interrupt-enable bit ie SHALL exist, set by opcode 00100 funct 01100 (EI) and cleared by funct 01101 (DI), both handled in DECODE and then going to FETCH.
- When an instruction completes with intr=1 and ie=1, the next state SHALL be INTA instead of FETCH.
- INTA SHALL assert inta=1, pcwrite=1 and pcsrc=10 for one cycle, clear ie, then go to FETCH.
REQ-030 Without that macro:
- intr SHALL be ignored, inta SHALL be constant 0, and state 7 SHALL be unreachable.
- EI and DI SHALL behave as NOP.

Verification
REQ-031 Reset, then opcode 00000 with mem_ready=1 on FETCH -> states 0,1,2,0; Accwrite=1 for exactly one cycle.
REQ-032 LDA with mem_ready low for 3 cycles in MRD -> read held 4 cycles, Accwrite=1 only on the 4th, bus_err=0.
REQ-033 JNZ with z=1 -> pcwrite=0 in BRANCH; repeat with z=0 -> pcwrite=1, pcsrc=01.
REQ-034 STA with mem_ready never asserted, WAIT_MAX=7 -> write high 7 cycles, then HALT with bus_err=1; only reset recovers.
REQ-035 With INTR_EN: EI, then ALU op with intr=1 -> after ALU, state 7 with inta=1, pcsrc=10, and ie=0 afterwards.
REQ-036 Reset asserted mid-MRD -> all strobes go to 0 without waiting for clk; after release, state_o=0 and read=1.
